// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus datapath: fetch (T0-T2) and
// execute (T3-T6) of register ALU, MUL/DIV, NOP and HALT instructions.
module control_sequencer #(
    parameter int             OPW     = 5,
    parameter logic [OPW-1:0] MUL_OP  = 5'd15,
    parameter logic [OPW-1:0] DIV_OP  = 5'd16,
    parameter logic [OPW-1:0] NOP_OP  = 5'd26,
    parameter logic [OPW-1:0] HALT_OP = 5'd27
) (
    input  logic           Clock,
    input  logic           clear,
    input  logic           run,
    input  logic [31:0]    IR,
    input  logic           mem_ready,
    output logic           PCout,
    output logic           Zlowout,
    output logic           Zhighout,
    output logic           HIout,
    output logic           LOout,
    output logic           MDRout,
    output logic           MARin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           HIin,
    output logic           LOin,
    output logic           Zin_low,
    output logic           Zin_high,
    output logic           IncPC,
    output logic           Read,
    output logic [15:0]    Rout,
    output logic [15:0]    Rin,
    output logic [OPW-1:0] alu_op,
    output logic [3:0]     step,
    output logic           halted,
    output logic           illegal
);

    typedef enum logic [3:0] {
        IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
        T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8
    } state_t;

    state_t         state;
    logic [OPW-1:0] opcode;
    logic [15:0]    ra_sel, rb_sel, rc_sel;
    logic           is_alu, is_md, is_halt, is_illegal;
    logic           unused_ir;

    assign opcode     = IR[31:32-OPW];
    assign ra_sel     = 16'd1 << IR[26:23];
    assign rb_sel     = 16'd1 << IR[22:19];
    assign rc_sel     = 16'd1 << IR[18:15];
    assign is_alu     = opcode < MUL_OP;
    assign is_md      = (opcode == MUL_OP) || (opcode == DIV_OP);
    assign is_halt    = opcode == HALT_OP;
    assign is_illegal = opcode > HALT_OP;
    assign unused_ir  = ^IR[14:0];

    // Opcodes between DIV and HALT other than NOP have no execute sequence
    // here; they retire from T3 exactly like NOP, without flagging illegal.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (run) state <= T0;
                T0:   state <= T1;
                T1:   if (mem_ready) state <= T2;
                T2:   state <= T3;
                T3: begin
                    if (is_halt)               state <= HALT;
                    else if (is_alu || is_md)  state <= T4;
                    else                       state <= run ? T0 : IDLE;
                end
                T4:   state <= T5;
                T5:   state <= is_md ? T6 : (run ? T0 : IDLE);
                T6:   state <= run ? T0 : IDLE;
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    assign step = state;

    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; HIout = 1'b0;
        LOout = 1'b0; MDRout = 1'b0; MARin = 1'b0; PCin = 1'b0;
        MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; HIin = 1'b0; LOin = 1'b0;
        Zin_low = 1'b0; Zin_high = 1'b0; IncPC = 1'b0; Read = 1'b0;
        Rout = '0; Rin = '0; alu_op = '0; halted = 1'b0; illegal = 1'b0;
        case (state)
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin_low = 1'b1;
            end
            // Held through memory wait; reloading PC from Zlow each cycle is harmless.
            T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            T3: begin
                if (is_alu) begin
                    Rout = rb_sel; Yin = 1'b1;
                end else if (is_md) begin
                    Rout = ra_sel; Yin = 1'b1;
                end
                illegal = is_illegal;
            end
            T4: begin
                alu_op  = opcode;
                Zin_low = 1'b1;
                if (is_md) begin
                    Rout = rb_sel; Zin_high = 1'b1;
                end else begin
                    Rout = rc_sel;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_md) LOin = 1'b1;
                else       Rin  = ra_sel;
            end
            T6: begin
                Zhighout = 1'b1; HIin = 1'b1;
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus random instructions checked
// cycle by cycle against a per-instruction expected microstep schedule.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        clear, run, mem_ready;
    logic [31:0] IR;
    logic        PCout, Zlowout, Zhighout, HIout, LOout, MDRout, MARin, PCin, MDRin, IRin;
    logic        Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read, halted, illegal;
    logic [15:0] Rout, Rin;
    logic [4:0]  alu_op;
    logic [3:0]  step;

    int checks = 0;
    int failures = 0;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .run(run), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
        .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .Zin_low(Zin_low), .Zin_high(Zin_high), .IncPC(IncPC),
        .Read(Read), .Rout(Rout), .Rin(Rin), .alu_op(alu_op), .step(step),
        .halted(halted), .illegal(illegal)
    );

    always #5 Clock = ~Clock;

    // Strobe bit positions inside the packed signal vector.
    localparam logic [18:0] M_PCOUT = 19'd1 << 18, M_ZLOWOUT = 19'd1 << 17, M_ZHIGHOUT = 19'd1 << 16;
    localparam logic [18:0] M_MDROUT = 19'd1 << 13, M_MARIN = 19'd1 << 12, M_PCIN = 19'd1 << 11;
    localparam logic [18:0] M_MDRIN = 19'd1 << 10, M_IRIN = 19'd1 << 9, M_YIN = 19'd1 << 8;
    localparam logic [18:0] M_HIIN = 19'd1 << 7, M_LOIN = 19'd1 << 6, M_ZINLOW = 19'd1 << 5;
    localparam logic [18:0] M_ZINHIGH = 19'd1 << 4, M_INCPC = 19'd1 << 3, M_READ = 19'd1 << 2;
    localparam logic [18:0] M_HALTED = 19'd1 << 1, M_ILLEGAL = 19'd1;

    typedef struct packed {
        logic [3:0]  step;
        logic [18:0] sig;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  alu;
    } obs_t;

    obs_t exp_q[$];

    function automatic obs_t mk(input logic [3:0] s, input logic [18:0] g,
                                input logic [15:0] ro, input logic [15:0] ri, input logic [4:0] a);
        obs_t o;
        o.step = s; o.sig = g; o.rout = ro; o.rin = ri; o.alu = a;
        return o;
    endfunction

    function automatic obs_t actual();
        return mk(step, {PCout, Zlowout, Zhighout, HIout, LOout, MDRout, MARin, PCin, MDRin, IRin,
                         Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read, halted, illegal},
                  Rout, Rin, alu_op);
    endfunction

    task automatic check(input string tag, input obs_t e);
        obs_t a;
        a = actual();
        checks++;
        assert (a === e) else begin
            failures++;
            $error("FAIL %s: got step=%0d sig=%h rout=%h rin=%h alu=%0d, expected step=%0d sig=%h rout=%h rin=%h alu=%0d",
                   tag, a.step, a.sig, a.rout, a.rin, a.alu, e.step, e.sig, e.rout, e.rin, e.alu);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Expected cycle schedule of one instruction from T0 to its last state.
    task automatic build(input logic [31:0] ir, input int w);
        logic [4:0]  op;
        logic [15:0] ra, rb, rc;
        op = ir[31:27];
        ra = 16'd1 << ir[26:23];
        rb = 16'd1 << ir[22:19];
        rc = 16'd1 << ir[18:15];
        exp_q.delete();
        exp_q.push_back(mk(4'd1, M_PCOUT | M_MARIN | M_INCPC | M_ZINLOW, '0, '0, '0));
        for (int k = 0; k <= w; k++)
            exp_q.push_back(mk(4'd2, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, '0, '0, '0));
        exp_q.push_back(mk(4'd3, M_MDROUT | M_IRIN, '0, '0, '0));
        if (op <= 5'd14) begin
            exp_q.push_back(mk(4'd4, M_YIN, rb, '0, '0));
            exp_q.push_back(mk(4'd5, M_ZINLOW, rc, '0, op));
            exp_q.push_back(mk(4'd6, M_ZLOWOUT, '0, ra, '0));
        end else if (op == 5'd15 || op == 5'd16) begin
            exp_q.push_back(mk(4'd4, M_YIN, ra, '0, '0));
            exp_q.push_back(mk(4'd5, M_ZINLOW | M_ZINHIGH, rb, '0, op));
            exp_q.push_back(mk(4'd6, M_ZLOWOUT | M_LOIN, '0, '0, '0));
            exp_q.push_back(mk(4'd7, M_ZHIGHOUT | M_HIIN, '0, '0, '0));
        end else begin
            exp_q.push_back(mk(4'd4, (op >= 5'd28) ? M_ILLEGAL : 19'd0, '0, '0, '0));
        end
    endtask

    // Entered while sampling a T0 cycle; leaves at the next T0 (or just after T4 if abort_t4).
    task automatic run_instr(input string tag, input logic [31:0] ir, input int w,
                             input bit run_after, input bit abort_t4);
        int k;
        k = 0;
        IR = ir;
        build(ir, w);
        for (int i = 0; i < exp_q.size(); i++) begin
            check(tag, exp_q[i]);
            if (abort_t4 && exp_q[i].step == 4'd5) return;
            if (exp_q[i].step == 4'd2) begin
                mem_ready = (k == w);
                k++;
            end else begin
                mem_ready = 1'($urandom);
            end
            run = (i == exp_q.size() - 1) ? run_after : 1'($urandom);
            tick();
        end
        if (!run_after) begin
            check({tag, "_idle"}, mk(4'd0, '0, '0, '0, '0));
            run = 1'b1;
            tick();
        end
    endtask

    always @(negedge Clock) begin
        checks++;
        assert ($countones({Rout, PCout, Zlowout, Zhighout, HIout, LOout, MDRout}) <= 1) else begin
            failures++;
            $error("FAIL bus_excl: got %0d sources, expected at most 1",
                   $countones({Rout, PCout, Zlowout, Zhighout, HIout, LOout, MDRout}));
        end
    end

    initial begin
        logic [31:0] r;
        logic [4:0]  op;
        int          sel;
        clear = 1'b0; run = 1'b0; mem_ready = 1'b1; IR = '0;
        #12;
        check("reset", mk(4'd0, '0, '0, '0, '0));
        clear = 1'b1;
        tick();
        check("idle_norun", mk(4'd0, '0, '0, '0, '0));
        run = 1'b1;
        tick();

        run_instr("and", 32'h1120_0000, 0, 1, 0);
        run_instr("and_wait", 32'h1120_0000, 3, 1, 0);
        run_instr("mul", 32'h7890_0000, 0, 1, 0);
        run_instr("div", {5'd16, 4'd7, 4'd9, 19'd0}, 1, 0, 0);
        run_instr("nop", {5'd26, 27'h5A5_A5A5}, 0, 1, 0);
        run_instr("illegal30", {5'd30, 27'h7FF_FFFF}, 2, 1, 0);
        run_instr("r0_dst", {5'd5, 4'd0, 4'd15, 4'd14, 15'd0}, 0, 1, 0);

        run_instr("halt", {5'd27, 27'd0}, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            check("halt_hold", mk(4'd8, M_HALTED, '0, '0, '0));
            run = 1'b1;
            tick();
        end
        clear = 1'b0;
        #1;
        check("halt_clear", mk(4'd0, '0, '0, '0, '0));
        run = 1'b0;
        #2 clear = 1'b1;
        tick();
        check("halt_release", mk(4'd0, '0, '0, '0, '0));
        run = 1'b1;
        tick();

        run_instr("rst_t4", 32'h7890_0000, 1, 1, 1);
        clear = 1'b0;
        #1;
        check("rst_async", mk(4'd0, '0, '0, '0, '0));
        run = 1'b0;
        #2 clear = 1'b1;
        tick();
        check("rst_idle1", mk(4'd0, '0, '0, '0, '0));
        tick();
        check("rst_idle2", mk(4'd0, '0, '0, '0, '0));
        run = 1'b1;
        tick();

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 21);
            if (sel <= 16)      op = 5'(sel);
            else if (sel == 17) op = 5'd26;
            else                op = 5'(sel + 10);
            r = $urandom();
            run_instr("rand", {op, r[26:0]}, $urandom_range(0, 3), 1'($urandom), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit that sequences the single-bus datapath, covering the register file R0–R15, PC, IR, MAR/MDR, Y, Zhigh/Zlow and HI/LO.
- It drives every register-in and bus-out strobe, the memory Read, IncPC and the ALU operation code.
- It runs the fetch phase (T0–T2) and the execute phase (T3–T6) for register-register ALU, MUL/DIV, NOP and HALT instructions.
- It sits beside the datapath, reads IR_data back from it, and has a memory-ready handshake.

Parameters:
- OPW, 5, opcode width; opcode = IR[31:27].
- MUL_OP, 5'd15, opcode of MUL; writes the 64-bit result to HI/LO.
- DIV_OP, 5'd16, opcode of DIV; quotient to LO, remainder to HI.
- NOP_OP, 5'd26, no-operation opcode.
- HALT_OP, 5'd27, halt opcode.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 allows a new fetch to start.
- IR  in  32  current instruction; Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- mem_ready  in  1  memory read data valid.
- PCout, Zlowout, Zhighout, HIout, LOout, MDRout  out  1 each  bus-source strobes.
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read  out  1 each  load/control strobes.
- Rout  out  16  one-hot register-file bus-source select.
- Rin  out  16  one-hot register-file load enable.
- alu_op  out  5  ALU operation; equals opcode in T4, 0 otherwise.
- step  out  4  current state encoding, for debug.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse in T3 for an undefined opcode (28–31).

Behaviour:
- States and encodings: IDLE=0, T0..T6=1..7, HALT=8.
  - The state register resets asynchronously to IDLE when clear=0.
  - All outputs are decoded combinationally from the state and IR only (Moore).
  - In IDLE every output is 0 and step=0.
- Bus exclusivity: in every state exactly zero or one bus-source strobe (including Rout bits) is high.
- IDLE: go to T0 if run=1, else stay.
- T0: assert PCout, MARin, IncPC, Zin_low. Go to T1.
- T1: assert Zlowout, PCin, Read, MDRin.
  - If mem_ready=0, stay in T1 with the same strobes held; re-loading PC from Zlow is idempotent.
  - If mem_ready=1, go to T2.
- T2: assert MDRout, IRin. Go to T3.
- T3, decided on IR[31:27]:
  - HALT_OP: go to HALT; no strobes in T3.
  - NOP_OP or illegal: go to the end-of-instruction decision; illegal=1 this cycle.
  - ALU (0–14): Rout[Rb]=1, Yin=1. Go to T4.
  - MUL/DIV: Rout[Ra]=1, Yin=1. Go to T4.
- T4:
  - ALU: Rout[Rc], alu_op=opcode, Zin_low.
  - MUL/DIV: Rout[Rb], alu_op=opcode, Zin_low and Zin_high.
  - Go to T5.
- T5:
  - ALU: Zlowout, Rin[Ra]; then end of instruction.
  - MUL/DIV: Zlowout, LOin; go to T6.
- T6: Zhighout, HIin; then end of instruction.
- End of instruction: go to T0 if run=1, else IDLE. run is sampled only here and in IDLE; deasserting run mid-instruction never truncates it.
- HALT: halted=1, all other strobes 0; stay until clear=0.
- Latency: ALU and NOP/illegal instructions take 6 and 4 cycles respectively, plus mem_ready wait cycles. MUL/DIV take 7 cycles.
- R0 as destination: Rin[0] is asserted normally; the sequencer does not special-case it.
- Reset mid-instruction (including during a T1 wait): all outputs drop to 0 immediately and asynchronously; the state is IDLE after release.
- IR must be stable from T3 through the last T-state; IR only changes via IRin in T2.

Test Plan:
- Reset, run=1, mem_ready=1, IR=0x1120_0000 (opcode 2 AND, Ra=2, Rb=4, Rc=0) → step goes 1,2,3,4,5,6. Rout=0x0010 in T3; Rout=0x0001 and alu_op=2 in T4; Rin=0x0004 in T5; then T0 again.
- Hold mem_ready=0 for 3 cycles in T1 → step stays 2 for 3 cycles with Read=MDRin=PCin=1; T2 follows the cycle after mem_ready=1.
- IR=0x7890_0000 (MUL, Ra=1, Rb=2) → Zin_low=Zin_high=1 in T4; LOin in T5; HIin in T6; 7-cycle instruction.
- IR opcode 27 → step=8, halted=1 held for 20 cycles despite run=1. clear=0 → step=0, halted=0.
- IR opcode 30 → illegal pulses one cycle in T3; no Rin or Yin; returns to T0.
- clear=0 asserted during T4 → all outputs 0 within the same cycle; run=0 after release keeps step=0.
- Every cycle of all scenarios → at most one bus source high (assertion checker).
